// File: rtl/mat_stream_loader.sv
// mat_stream_loader
//
// Collects a stream of N*N complex A elements followed by N*N complex B
// elements into packed operand matrices, hands them to an external matrix
// multiplier with a one-cycle valid strobe followed by a two-cycle start
// strobe, waits a bounded number of cycles for the result and streams the
// N*N result elements back out in row-major order.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   in_valid/in_ready input element handshake
//   in_real/in_imag   input element (64-bit real, 64-bit imaginary)
//   mat_a, mat_b      packed operand matrices to the multiplier
//   mm_valid          registered operands-valid strobe to the multiplier
//   mm_start          registered start command to the multiplier
//   mm_done, mat_out  multiplier completion and packed result
//   out_valid/ready   output element handshake
//   out_real/out_imag output element
//   out_last          output element is element N*N-1
//   timeout           sticky: the multiplier did not answer in WAIT_LIMIT cycles
//
// Packing (mat_a, mat_b, mat_out): element k = r*N + c has its real part at
// [64k +: 64] and its imaginary part at [64(N*N+k) +: 64].
//
// state  | meaning
// LOAD_A | accepting A elements, cnt = next A element index
// LOAD_B | accepting B elements, cnt = next B element index
// VALID  | one cycle of mm_valid before the start command
// START  | two cycles of mm_valid + mm_start
// WAIT   | waiting for mm_done, bounded by WAIT_LIMIT cycles
// DRAIN  | presenting result element cnt on the output stream

module mat_stream_loader #(
  parameter int mat_num_row = 4,
  parameter int WAIT_LIMIT  = 1024
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [63:0]                              in_real,
  input  logic [63:0]                              in_imag,
  output logic [128*mat_num_row*mat_num_row-1:0]   mat_a,
  output logic [128*mat_num_row*mat_num_row-1:0]   mat_b,
  output logic                                     mm_valid,
  output logic                                     mm_start,
  input  logic                                     mm_done,
  input  logic [128*mat_num_row*mat_num_row-1:0]   mat_out,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [63:0]                              out_real,
  output logic [63:0]                              out_imag,
  output logic                                     out_last,
  output logic                                     timeout
);

  localparam int NN = mat_num_row * mat_num_row;
  localparam int MW = 128 * NN;
  localparam int CW = $clog2(NN) + 1;
  localparam int WW = $clog2(WAIT_LIMIT + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(NN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_VALID  = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            start_2nd_q, start_2nd_d;
  logic            mm_valid_q, mm_valid_d;
  logic            mm_start_q, mm_start_d;
  logic            timeout_q, timeout_d;
  logic [MW-1:0]   mat_a_q, mat_a_d;
  logic [MW-1:0]   mat_b_q, mat_b_d;
  logic [MW-1:0]   res_q, res_d;

  logic            in_xfer;
  logic            out_xfer;

  // Returns m with element idx replaced by (re, im).
  function automatic logic [MW-1:0] write_elem(input logic [MW-1:0] m,
                                               input logic [CW-1:0] idx,
                                               input logic [63:0]   re,
                                               input logic [63:0]   im);
    logic [MW-1:0] r;
    r = m;
    for (int k = 0; k < NN; k++) begin
      if (idx == CW'(k)) begin
        r[64*k +: 64]      = re;
        r[64*(NN+k) +: 64] = im;
      end
    end
    return r;
  endfunction

  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = out_valid && (cnt_q == CNT_LAST);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign mat_a    = mat_a_q;
  assign mat_b    = mat_b_q;
  assign mm_valid = mm_valid_q;
  assign mm_start = mm_start_q;
  assign timeout  = timeout_q;

  // Output element mux; follows cnt so it holds while out_ready is low.
  always_comb begin
    out_real = '0;
    out_imag = '0;
    for (int k = 0; k < NN; k++) begin
      if (cnt_q == CW'(k)) begin
        out_real = res_q[64*k +: 64];
        out_imag = res_q[64*(NN+k) +: 64];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = '0;
    start_2nd_d = 1'b0;
    timeout_d   = timeout_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    res_d       = res_q;

    case (state_q)
      S_LOAD_A: begin
        if (in_xfer) begin
          mat_a_d = write_elem(mat_a_q, cnt_q, in_real, in_imag);
          // First A element of a new pass acknowledges a previous timeout.
          if (cnt_q == '0) timeout_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_LOAD_B: begin
        if (in_xfer) begin
          mat_b_d = write_elem(mat_b_q, cnt_q, in_real, in_imag);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_VALID;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_VALID: begin
        state_d = S_START;
      end

      S_START: begin
        start_2nd_d = 1'b1;
        if (start_2nd_q) begin
          start_2nd_d = 1'b0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        // wait_q counts completed WAIT cycles; a result arriving on the
        // final permitted cycle still wins over the timeout.
        if (mm_done) begin
          res_d   = mat_out;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (wait_q == WAIT_LAST) begin
          res_d     = '0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_DRAIN;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      S_DRAIN: begin
        if (out_xfer) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the
  // cycles spent in VALID/START.
  always_comb begin
    mm_valid_d = (state_d == S_VALID) || (state_d == S_START);
    mm_start_d = (state_d == S_START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      wait_q      <= '0;
      start_2nd_q <= 1'b0;
      mm_valid_q  <= 1'b0;
      mm_start_q  <= 1'b0;
      timeout_q   <= 1'b0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      start_2nd_q <= start_2nd_d;
      mm_valid_q  <= mm_valid_d;
      mm_start_q  <= mm_start_d;
      timeout_q   <= timeout_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      res_q       <= res_d;
    end
  end

endmodule

// File: doc/mat_stream_loader.md
MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

Interface
REQ-001 Parameter: mat_num_row, default 4, matrix dimension N; all matrices are square N x N complex.
REQ-002 Parameter: WAIT_LIMIT, default 1024, maximum number of cycles spent waiting for mm_done before a timeout.
REQ-003 Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element present.
- in_ready  out  1  loader accepts the input element this cycle.
- in_real  in  64  real part of the input element.
- in_imag  in  64  imaginary part of the input element.
- mat_a  out  128*N*N  A matrix to the multiplier.
- mat_b  out  128*N*N  B matrix to the multiplier.
- mm_valid  out  1  inputs-valid strobe to the multiplier.
- mm_start  out  1  start command to the multiplier.
- mm_done  in  1  multiplier result ready.
- mat_out  in  128*N*N  multiplier result.
- out_valid  out  1  output element present.
- out_ready  in  1  consumer accepts the output element.
- out_real  out  64  real part of the output element.
- out_imag  out  64  imaginary part of the output element.
- out_last  out  1  current output element is element N*N-1.
- timeout  out  1  sticky flag: the WAIT_LIMIT expired.

Function
REQ-004 Packing: element k (row-major, k = r*N + c) places its real part at bits [64k +: 64] and its imaginary part at bits [64(N*N+k) +: 64]; this applies to mat_a, mat_b and mat_out.
REQ-005 The input stream carries N*N A elements in row-major order, followed by N*N B elements in row-major order.
REQ-006 A transfer occurs only when in_valid and in_ready are both 1; out_valid and out_ready follow the same rule.
REQ-007 The FSM has states LOAD_A, LOAD_B, VALID, START, WAIT and DRAIN. It uses a single element counter with width $clog2(N*N)+1.
REQ-008 LOAD_A:
- in_ready = 1.
- Each transfer writes element cnt of mat_a and increments cnt.
- On the transfer of element N*N-1, the FSM clears cnt and moves to LOAD_B.
REQ-009 LOAD_B: behaves the same as LOAD_A but writes mat_b; after element N*N-1 the FSM moves to VALID.
REQ-010 in_ready = 0 in every state other than LOAD_A and LOAD_B.
REQ-011 VALID lasts exactly 1 cycle, with mm_valid = 1 and mm_start = 0; the FSM then moves to START.
REQ-012 START lasts exactly 2 cycles, with mm_valid = 1 and mm_start = 1; the FSM then moves to WAIT.
REQ-013 mm_valid and mm_start are registered, and both are 0 in every other state.
REQ-014 WAIT:
- A wait counter increments every cycle.
- When mm_done = 1, the loader captures mat_out into an internal result register in that same cycle, clears cnt and moves to DRAIN.
REQ-015 WAIT timeout: if the wait counter reaches WAIT_LIMIT with mm_done still 0, then:
- timeout is set to 1;
- the result register is zero-filled;
- the FSM moves to DRAIN (so the consumer is never hung).
REQ-016 mm_done arriving in the same cycle as the limit is reached takes priority: the result is captured and timeout is not set.
REQ-017 DRAIN: out_valid = 1, and out_real/out_imag present element cnt of the result register.
REQ-018 DRAIN: each output transfer increments cnt. out_last = 1 exactly when cnt = N*N-1.
REQ-019 The transfer of the last element returns the FSM to LOAD_A with cnt = 0.
REQ-020 While out_ready = 0 in DRAIN, out_real, out_imag, out_valid and out_last hold stable.
REQ-021 mat_a and mat_b hold their values from the end of LOAD_B until they are overwritten in the next LOAD_A/LOAD_B pass.
REQ-022 timeout clears only on reset or on the first input transfer of the next LOAD_A.
REQ-023 mm_done in any state other than WAIT is ignored.
REQ-024 Latency from the last B transfer to the first out_valid is 1 (VALID) + 2 (START) + the number of WAIT cycles up to and including the mm_done cycle, + 1 cycle.
REQ-025 Throughput: one element per cycle in both directions with no bubbles while the handshake partner stays ready.

Reset
REQ-026 Asserting rst forces the following immediately, in any state including mid-load or mid-drain:
- FSM = LOAD_A;
- cnt = 0 and the wait counter = 0;
- in_ready = 1;
- mm_valid = 0 and mm_start = 0;
- out_valid = 0, out_last = 0 and timeout = 0;
- mat_a, mat_b, the result register, out_real and out_imag = 0.
REQ-027 After rst is released, the first clk edge may accept an input element.

Verification
REQ-028 The bench uses N=2, with scenarios as follows:
- Basic load: stream A = {1,2,3,4} and B = {5,6,7,8} (imaginary parts 0) with in_valid held high. Required response: mat_a real words = 1,2,3,4 at k = 0..3, mat_b real words = 5..8, in_ready drops after the 8th transfer, mm_valid is high for 1 cycle, then mm_valid and mm_start are high for 2 cycles.
- Result drain: model mm_done 5 cycles after START with mat_out real = {19,22,43,50} and imaginary = {1,2,3,4}. Required response: 4 output beats in row-major order, out_last on the 4th beat only, then in_ready = 1.
- Backpressure: toggle in_valid and out_ready randomly. Required response: no element lost or duplicated, and outputs stay stable while stalled.
- Timeout: set WAIT_LIMIT = 8 and never assert mm_done. Required response: timeout = 1 after 8 WAIT cycles, 4 zero-valued output beats, and timeout clears on the next A transfer.
- Reset mid-operation: assert rst after 3 A elements, then reload the full A and B set. Required response: all outputs return to their reset values and the new data packs from k = 0.
- Stray mm_done: pulse mm_done during LOAD_B. Required response: no state change and no out_valid.
